// File: rtl/u0_bus_host.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | u0_bus_host : CPU-side bus master for USART0. Runs register init, then   |
// |               services rx/tc/tx interrupts and buffers RX bytes.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module u0_bus_host #(
  parameter logic [7:0]  UBRRL_ADDR = 8'hC4,
  parameter logic [7:0]  UBRRH_ADDR = 8'hC5,
  parameter logic [7:0]  UCSRC_ADDR = 8'hC2,
  parameter logic [7:0]  UCSRB_ADDR = 8'hC1,
  parameter logic [7:0]  UDR_ADDR   = 8'hC6,
  parameter logic [11:0] BAUD_DIV   = 12'd103,
  parameter logic [7:0]  UCSRC_VAL  = 8'h06,
  parameter logic [7:0]  UCSRB_VAL  = 8'hF8,
  parameter int          RXF_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       read,
  output logic       write,
  output logic [7:0] addr,
  output logic [7:0] din,
  input  logic [7:0] dout,
  input  logic       txir,
  output logic       txack,
  input  logic       rxir,
  output logic       rxack,
  input  logic       tcir,
  output logic       tcack,
  output logic       init_done,
  output logic       tx_done,
  output logic       rx_overrun,
  input  logic       ovr_clr
);

  localparam int              c_AW   = $clog2(RXF_DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(RXF_DEPTH);

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_IDLE,
    S_RD, S_CAP, S_RACK, S_TC, S_TXWR, S_GAP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        w_read, w_write, w_txack, w_rxack, w_tcack, w_tx_ready, w_tx_done;
  logic        w_init_set, w_push;
  logic [7:0]  w_addr, w_din;

  logic        r_read, r_write, r_txack, r_rxack, r_tcack, r_tx_ready, r_tx_done;
  logic        r_init_done, r_rx_overrun, r_rx_valid;
  logic [7:0]  r_addr, r_din;

  logic [7:0]    r_mem [RXF_DEPTH];
  logic [c_AW-1:0] r_wptr, r_rptr;
  logic [c_AW:0] r_count, w_count_nxt;
  logic          w_pop, w_full, w_push_ok, w_drop;

  // Outputs are decided here for the state being entered, so every strobe
  // is visible in the cycle the FSM occupies the corresponding state.
  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    w_write     = 1'b0;
    w_txack     = 1'b0;
    w_rxack     = 1'b0;
    w_tcack     = 1'b0;
    w_tx_ready  = 1'b0;
    w_tx_done   = 1'b0;
    w_init_set  = 1'b0;
    w_push      = 1'b0;
    w_addr      = 8'h00;
    w_din       = 8'h00;
    case (r_state)
      S_INIT0: begin
        w_write = 1'b1; w_addr = UBRRL_ADDR; w_din = BAUD_DIV[7:0];
        w_state_nxt = S_INIT1;
      end
      S_INIT1: begin
        w_write = 1'b1; w_addr = UBRRH_ADDR; w_din = {4'h0, BAUD_DIV[11:8]};
        w_state_nxt = S_INIT2;
      end
      S_INIT2: begin
        w_write = 1'b1; w_addr = UCSRC_ADDR; w_din = UCSRC_VAL;
        w_state_nxt = S_INIT3;
      end
      S_INIT3: begin
        w_write = 1'b1; w_addr = UCSRB_ADDR; w_din = UCSRB_VAL;
        w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        w_init_set = 1'b1;
        if (rxir) begin
          w_read = 1'b1; w_addr = UDR_ADDR;
          w_state_nxt = S_RD;
        end else if (tcir) begin
          w_tcack = 1'b1; w_tx_done = 1'b1;
          w_state_nxt = S_TC;
        end else if (txir && tx_valid) begin
          w_write = 1'b1; w_addr = UDR_ADDR; w_din = tx_data;
          w_tx_ready = 1'b1; w_txack = 1'b1;
          w_state_nxt = S_TXWR;
        end
      end
      S_RD:   w_state_nxt = S_CAP;
      S_CAP: begin
        w_push = 1'b1; w_rxack = 1'b1;
        w_state_nxt = S_RACK;
      end
      S_RACK: w_state_nxt = S_IDLE;
      S_TC:   w_state_nxt = S_IDLE;
      S_TXWR: w_state_nxt = S_GAP;
      S_GAP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_INIT0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_txack      <= 1'b0;
      r_rxack      <= 1'b0;
      r_tcack      <= 1'b0;
      r_tx_ready   <= 1'b0;
      r_tx_done    <= 1'b0;
      r_addr       <= 8'h00;
      r_din        <= 8'h00;
      r_init_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_read       <= w_read;
      r_write      <= w_write;
      r_txack      <= w_txack;
      r_rxack      <= w_rxack;
      r_tcack      <= w_tcack;
      r_tx_ready   <= w_tx_ready;
      r_tx_done    <= w_tx_done;
      r_addr       <= w_addr;
      r_din        <= w_din;
      r_init_done  <= r_init_done | w_init_set;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_pop     = r_rx_valid && rx_ready;
  assign w_full    = (r_count == c_FULL);
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count    <= w_count_nxt;
      r_rx_valid <= (w_count_nxt != '0);
      if (w_drop)       r_rx_overrun <= 1'b1;
      else if (ovr_clr) r_rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= dout;
  end

  assign read       = r_read;
  assign write      = r_write;
  assign addr       = r_addr;
  assign din        = r_din;
  assign txack      = r_txack;
  assign rxack      = r_rxack;
  assign tcack      = r_tcack;
  assign tx_ready   = r_tx_ready;
  assign tx_done    = r_tx_done;
  assign init_done  = r_init_done;
  assign rx_overrun = r_rx_overrun;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_u0_bus_host.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_u0_bus_host : directed self-checking bench for u0_bus_host.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_u0_bus_host;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       read, write;
  logic [7:0] addr, din;
  logic [7:0] dout = 8'h00;
  logic       txir = 1'b0, rxir = 1'b0, tcir = 1'b0, ovr_clr = 1'b0;
  logic       txack, rxack, tcack, init_done, tx_done, rx_overrun;

  int n_checks = 0;
  int n_errors = 0;

  u0_bus_host dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .read(read), .write(write), .addr(addr), .din(din), .dout(dout),
    .txir(txir), .txack(txack), .rxir(rxir), .rxack(rxack),
    .tcir(tcir), .tcack(tcack), .init_done(init_done), .tx_done(tx_done),
    .rx_overrun(rx_overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_init();
    logic [7:0] a_tab [4];
    logic [7:0] d_tab [4];
    a_tab = '{8'hC4, 8'hC5, 8'hC2, 8'hC1};
    d_tab = '{8'h67, 8'h00, 8'h06, 8'hF8};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("init_wr%0d", i), {read, write, addr, din}, {1'b0, 1'b1, a_tab[i], d_tab[i]});
      chk($sformatf("init_done_lo%0d", i), init_done, 1'b0);
    end
    tick();
    chk("init_done", {init_done, write, read}, 3'b100);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rxir = 1'b1;
    tick();
    chk("rx_read", {read, write, addr}, {1'b1, 1'b0, 8'hC6});
    dout = b;
    tick();
    chk("rx_cap_quiet", {read, rxack}, 2'b00);
    tick();
    chk("rx_ack", rxack, 1'b1);
    rxir = 1'b0;
    tick();
    chk("rx_ack_pulse", {rxack, read}, 2'b00);
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_flags", {read, write, txack, rxack, tcack, tx_ready, tx_done,
                      init_done, rx_overrun, rx_valid}, 10'h000);
    chk("rst_bus", {addr, din}, 16'h0000);
    rst = 1'b1;
    check_init();

    // TX path
    tx_valid = 1'b1; tx_data = 8'hA5; txir = 1'b1;
    tick();
    chk("tx_wr", {write, addr, din, txack, tx_ready}, {1'b1, 8'hC6, 8'hA5, 1'b1, 1'b1});
    txir = 1'b0;
    tick();
    chk("tx_gap", {write, txack, tx_ready}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tx_no_txir", {write, tx_ready}, 2'b00);
    end
    tx_valid = 1'b0;

    // RX path
    rx_byte(8'h3C);
    chk("rx_head", {rx_valid, rx_data}, {1'b1, 8'h3C});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_popped", rx_valid, 1'b0);

    // Priority rxir > tcir > txir
    rxir = 1'b1; tcir = 1'b1; txir = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
    tick();
    chk("pri_read_first", {read, write, tcack}, 3'b100);
    dout = 8'h11;
    tick();
    tick();
    chk("pri_rxack", rxack, 1'b1);
    rxir = 1'b0;
    tick();
    tick();
    chk("pri_tc", {tcack, tx_done, write, read}, 4'b1100);
    tcir = 1'b0;
    tick();
    chk("tx_done_pulse", {tcack, tx_done}, 2'b00);
    tick();
    chk("pri_tx_last", {write, din, txack}, {1'b1, 8'h5A, 1'b1});
    txir = 1'b0; tx_valid = 1'b0;
    tick();
    chk("pri_rx_data", {rx_valid, rx_data}, {1'b1, 8'h11});
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // Overrun: depth 4, fifth byte dropped
    for (int i = 1; i <= 5; i++) rx_byte(8'(i));
    chk("ovr_set", rx_overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_order%0d", i), {rx_valid, rx_data}, {1'b1, 8'(i)});
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk("ovr_empty", rx_valid, 1'b0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", rx_overrun, 1'b0);

    // Push into a full FIFO while popping: accepted, no overrun
    for (int i = 0; i < 4; i++) rx_byte(8'hB0 + 8'(i));
    rxir = 1'b1;
    tick();
    dout = 8'h55;
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0; rxir = 1'b0;
    chk("full_pp_ovr", rx_overrun, 1'b0);
    chk("full_pp_head", rx_data, 8'hB1);
    tick();
    begin
      logic [7:0] exp_q [4];
      exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'h55};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("full_pp_order%0d", i), {rx_valid, rx_data}, {1'b1, exp_q[i]});
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    end
    chk("full_pp_empty", rx_valid, 1'b0);

    // Reset during CAP
    rx_byte(8'h77);
    rxir = 1'b1;
    tick();
    dout = 8'h88;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_now", {read, rxack, rx_valid, init_done}, 4'b0000);
    rxir = 1'b0;
    tick();
    chk("mid_rst_held", {read, write, rxack, rx_valid}, 4'b0000);
    rst = 1'b1;
    check_init();
    chk("mid_rst_fifo", rx_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
